// File: rtl/uart_periph.sv
// uart_periph: memory-mapped UART (DATA/STATUS/DIV) with a TX FIFO and an optional receiver.
// The receiver is built only when UART_PERIPH_RX_EN is defined; otherwise RX status reads as zero.
//
// state   | meaning
// S_IDLE  | line idle; TX waits for FIFO data, RX waits for a falling edge
// S_START | start bit
// S_DATA  | 8 data bits, LSB first
// S_STOP  | stop bit
module uart_periph #(
  parameter int unsigned TX_DEPTH  = 4,
  parameter logic [15:0] DIV_RESET = 16'd868
) (
  input  logic        mem_clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        uart_tx,
  input  logic        uart_rx
);
  localparam int unsigned AW = $clog2(TX_DEPTH);
  localparam logic [AW:0] DEPTH_P = (AW+1)'(TX_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic        mem_ready_q;
  logic [31:0] mem_rdata_q, rdata_d, data_rd;
  logic        acc, wr, rd, sel_data, sel_stat, sel_div;
  logic [15:0] div_q;
  logic        ovr_tx_q;
  logic        rx_full, ovr_rx, ferr;
  logic        unused_wdata;

  assign acc      = mem_valid & ~mem_ready_q;
  assign wr       = acc & (|mem_wstrb);
  assign rd       = acc & ~(|mem_wstrb);
  assign sel_data = (mem_addr == 4'd0);
  assign sel_stat = (mem_addr == 4'd1);
  assign sel_div  = (mem_addr == 4'd2);
  assign unused_wdata = ^mem_wdata[31:16];
  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;

  logic [7:0]  fifo_mem [TX_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q, tx_used;
  logic        tx_full, tx_empty, tx_push, tx_pop;

  assign tx_used  = wr_ptr_q - rd_ptr_q;
  assign tx_full  = (tx_used == DEPTH_P);
  assign tx_empty = (tx_used == '0);
  // a pop in the same cycle frees a slot, so a push into a full FIFO still lands
  assign tx_push  = wr & sel_data & (~tx_full | tx_pop);

  always_comb begin
    rdata_d = 32'd0;
    if (rd) begin
      case (mem_addr)
        4'd0:    rdata_d = data_rd;
        4'd1:    rdata_d = {27'd0, ferr, ovr_rx, ovr_tx_q, rx_full, tx_full};
        4'd2:    rdata_d = {16'd0, div_q};
        default: rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge mem_clk) begin
    if (!rst_n) begin
      mem_ready_q <= 1'b0;
      mem_rdata_q <= 32'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      div_q       <= DIV_RESET;
      ovr_tx_q    <= 1'b0;
    end else begin
      mem_ready_q <= mem_valid & ~mem_ready_q;
      mem_rdata_q <= rdata_d;
      if (tx_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (tx_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr & sel_div) div_q <= (mem_wdata[15:0] < 16'd4) ? 16'd4 : mem_wdata[15:0];
      if (wr & sel_data & tx_full & ~tx_pop) ovr_tx_q <= 1'b1;
      else if (wr & sel_stat & mem_wdata[2]) ovr_tx_q <= 1'b0;
    end
  end

  always_ff @(posedge mem_clk) begin
    if (tx_push) fifo_mem[wr_ptr_q[AW-1:0]] <= mem_wdata[7:0];
  end

  state_e      tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;

  always_ff @(posedge mem_clk) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_div_q   <= 16'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'd0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  // divisor is latched at frame start so DIV writes mid-frame wait for the next frame
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      S_IDLE: if (!tx_empty) begin
        tx_state_d = S_START;
        tx_div_d   = div_q;
        tx_cnt_d   = div_q - 16'd1;
        tx_shift_d = fifo_mem[rd_ptr_q[AW-1:0]];
      end
      S_START: if (tx_cnt_q == 16'd0) begin
        tx_state_d = S_DATA;
        tx_cnt_d   = tx_div_q - 16'd1;
        tx_bit_d   = 3'd0;
      end else tx_cnt_d = tx_cnt_q - 16'd1;
      S_DATA: if (tx_cnt_q == 16'd0) begin
        tx_cnt_d   = tx_div_q - 16'd1;
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
        tx_bit_d   = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
      end else tx_cnt_d = tx_cnt_q - 16'd1;
      default: if (tx_cnt_q == 16'd0) tx_state_d = S_IDLE;
               else tx_cnt_d = tx_cnt_q - 16'd1;
    endcase
  end

  always_comb begin
    uart_tx = 1'b1;
    tx_pop  = 1'b0;
    case (tx_state_q)
      S_IDLE:  tx_pop  = ~tx_empty;
      S_START: uart_tx = 1'b0;
      S_DATA:  uart_tx = tx_shift_q[0];
      default: uart_tx = 1'b1;
    endcase
  end

`ifdef UART_PERIPH_RX_EN
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  state_e      rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d, rx_hold_q;
  logic        rx_full_q, ovr_rx_q, ferr_q;
  logic        rx_done, rx_good, rx_pop;

  always_ff @(posedge mem_clk) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_div_q   <= 16'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
    end else begin
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // first wait is half a bit so every later sample lands mid-bit
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    case (rx_state_q)
      S_IDLE: if (rx_prev_q & ~rx_s2_q) begin
        rx_state_d = S_START;
        rx_div_d   = div_q;
        rx_cnt_d   = {1'b0, div_q[15:1]} - 16'd1;
      end
      S_START: if (rx_cnt_q == 16'd0) begin
        rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        rx_cnt_d   = rx_div_q - 16'd1;
        rx_bit_d   = 3'd0;
      end else rx_cnt_d = rx_cnt_q - 16'd1;
      S_DATA: if (rx_cnt_q == 16'd0) begin
        rx_cnt_d   = rx_div_q - 16'd1;
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
      end else rx_cnt_d = rx_cnt_q - 16'd1;
      default: if (rx_cnt_q == 16'd0) rx_state_d = S_IDLE;
               else rx_cnt_d = rx_cnt_q - 16'd1;
    endcase
  end

  always_comb begin
    rx_done = (rx_state_q == S_STOP) && (rx_cnt_q == 16'd0);
    rx_good = rx_done & rx_s2_q;
  end

  assign rx_pop = rd & sel_data & rx_full_q;

  always_ff @(posedge mem_clk) begin
    if (!rst_n) begin
      rx_hold_q <= 8'd0;
      rx_full_q <= 1'b0;
      ovr_rx_q  <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      if (rx_good & (~rx_full_q | rx_pop)) begin
        rx_hold_q <= rx_shift_q;
        rx_full_q <= 1'b1;
      end else if (rx_pop) rx_full_q <= 1'b0;
      if (rx_good & rx_full_q & ~rx_pop) ovr_rx_q <= 1'b1;
      else if (wr & sel_stat & mem_wdata[3]) ovr_rx_q <= 1'b0;
      if (rx_done & ~rx_s2_q) ferr_q <= 1'b1;
      else if (wr & sel_stat & mem_wdata[4]) ferr_q <= 1'b0;
    end
  end

  assign rx_full = rx_full_q;
  assign ovr_rx  = ovr_rx_q;
  assign ferr    = ferr_q;
  assign data_rd = {~rx_full_q, 23'd0, rx_full_q ? rx_hold_q : 8'd0};
`else
  logic unused_rx;
  assign unused_rx = uart_rx;
  assign rx_full   = 1'b0;
  assign ovr_rx    = 1'b0;
  assign ferr      = 1'b0;
  assign data_rd   = 32'h8000_0000;
`endif

endmodule

// File: doc/uart_periph.md
UART_PERIPH -- requirements
Module: uart_periph

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 4, TX FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter DIV_RESET, default 16'd868, reset baud divisor (clocks per bit).
REQ-003 SHALL have port mem_clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port mem_valid, input, 1: decoded select for this peripheral.
REQ-006 SHALL have port mem_addr, input, 4: word index (system byte address [5:2]).
REQ-007 SHALL have port mem_wdata, input, 32: write data.
REQ-008 SHALL have port mem_wstrb, input, 4: byte strobes; nonzero means write, zero means read.
REQ-009 SHALL have port mem_ready, output, 1: one-cycle access completion pulse.
REQ-010 SHALL have port mem_rdata, output, 32: read data, valid while mem_ready=1, else 0.
REQ-011 SHALL have port uart_tx, output, 1: serial out, idle high.
REQ-012 SHALL have port uart_rx, input, 1: asynchronous serial in, idle high.

Function
REQ-013 SHALL drive mem_ready <= mem_valid & ~mem_ready, so each access completes exactly one cycle after mem_valid and never completes twice.
REQ-014 SHALL apply register side effects only in the cycle where mem_valid=1 and mem_ready=0.
REQ-015 SHALL decode word 0 DATA: write pushes wdata[7:0] to TX FIFO; read returns {empty,23'b0,byte} and pops the RX holding register if full.
REQ-016 SHALL decode word 1 STATUS: read {27'b0,ferr,ovr_rx,ovr_tx,rx_full,tx_full}; write-1-to-clear bits [4:2].
REQ-017 SHALL decode word 2 DIV: read/write bits [15:0]; a written value below 4 SHALL be stored as 4.
REQ-018 SHALL return 0 for reads of unmapped words and ignore writes to them.
REQ-019 SHALL drop a DATA write when TX FIFO is full and set ovr_tx.
REQ-020 SHALL run TX FSM IDLE->START->DATA(8 bits, LSB first)->STOP->IDLE, each state held DIV clocks.
REQ-021 SHALL leave IDLE on the first cycle the TX FIFO is non-empty, popping one entry on entry to START.
REQ-022 SHALL sample DIV at frame start; DIV writes mid-frame take effect on the next frame.
REQ-023 SHALL on simultaneous push and pop of the TX FIFO keep occupancy unchanged, even when full.
REQ-024 SHALL pass uart_rx through a two-flop synchronizer before any use.
REQ-025 SHALL run RX FSM IDLE->START->DATA->STOP->IDLE, detecting start on a falling edge and sampling each bit at DIV/2 clocks into the bit.
REQ-026 SHALL abort to IDLE if the start bit samples high at mid-bit (glitch rejection).
REQ-027 SHALL on a stop bit sampled low discard the byte and set ferr.
REQ-028 SHALL on a good stop bit with rx_full=1 discard the new byte and set ovr_rx; the held byte is retained.
REQ-029 SHALL on a good stop bit coinciding with a DATA read pop load the new byte without setting ovr_rx.

Reset
REQ-030 SHALL on rst_n=0 at a clock edge set mem_ready=0, mem_rdata=0, uart_tx=1, both FSMs to IDLE, FIFO empty, all flags 0, DIV=DIV_RESET.
REQ-031 SHALL abort any frame in progress at reset; uart_tx returns high in the same edge.

Configuration
REQ-032 SHALL compile the receiver only when macro UART_PERIPH_RX_EN is defined.
REQ-033 SHALL without UART_PERIPH_RX_EN tie rx_full, ovr_rx, ferr to 0, return DATA reads as 32'h8000_0000, and leave uart_rx unused.

Verification
REQ-034 SHALL cover: DIV=4, write DATA 0x55 -> uart_tx low 4 clocks, then 1,0,1,0,1,0,1,0 at 4 clocks each, then high 4 clocks.
REQ-035 SHALL cover: 5 back-to-back DATA writes while TX idle (TX_DEPTH=4) -> first pops immediately, all 5 transmitted, ovr_tx=0; 6 writes within one frame -> ovr_tx=1, 5 bytes sent.
REQ-036 SHALL cover: drive 0xA3 on uart_rx at DIV=8 -> rx_full=1, DATA read returns 0x0000_00A3, then next read returns 0x8000_0000.
REQ-037 SHALL cover: two frames 0x11,0x22 with no read -> ovr_rx=1, read returns 0x11; write STATUS 0x08 -> ovr_rx=0.
REQ-038 SHALL cover: frame with stop bit low -> ferr=1, rx_full=0; 2-clock low glitch at DIV=8 -> no flags, FSM back to IDLE.
REQ-039 SHALL cover: rst_n low mid-TX-frame for one cycle -> uart_tx=1 next cycle, FIFO empty, DIV reads DIV_RESET.
